// File: rtl/calc_top.sv
// calc_top: decimal calculator core (add, subtract, multiply) with an
// eight-digit 7-segment readout.
//
// Ports
//   clock     sole clock, rising edge
//   reset     synchronous active-low reset
//   cmd       held command code: 0-9 digit, A add, B sub, C mul,
//             D idle/separator, E equals, F clear
//   displays  eight 7-segment digits, [0] least significant, bit0=a..bit6=g
//   status    00 EDIT, 01 BUSY, 10 RESULT, 11 ERROR
//
// Build option
//   CALC_MUL_EN  defined: 27-cycle shift-and-add multiplier present.
//                undefined: code C is a plain separator, BUSY never entered.
//
// state  | meaning
// -------+----------------------------------------------------------
// EDIT   | entering A, or B once an operator is pending
// BUSY   | multiply in progress, only clear is honoured
// RESULT | result shown; digit starts new A, operator chains
// ERROR  | overflow or negative chain; only clear or reset leave

module calc_top (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] cmd,
  output logic [6:0] displays [7:0],
  output logic [1:0] status
);

  typedef enum logic [1:0] {
    S_EDIT   = 2'b00,
    S_BUSY   = 2'b01,
    S_RESULT = 2'b10,
    S_ERROR  = 2'b11
  } state_t;

  localparam logic [1:0]  OP_NONE  = 2'd0;
  localparam logic [1:0]  OP_ADD   = 2'd1;
  localparam logic [1:0]  OP_SUB   = 2'd2;
  localparam logic [3:0]  CMD_ADD  = 4'hA;
  localparam logic [3:0]  CMD_SUB  = 4'hB;
  localparam logic [3:0]  CMD_IDLE = 4'hD;
  localparam logic [3:0]  CMD_EQ   = 4'hE;
  localparam logic [3:0]  CMD_CLR  = 4'hF;
  localparam logic [28:0] MAX_MAG  = 29'd99_999_999;
  localparam logic [6:0]  SEG_MINUS = 7'b1000000;
  localparam logic [6:0]  SEG_E     = 7'b1111001;
  localparam logic [6:0]  SEG_R     = 7'b1010000;
`ifdef CALC_MUL_EN
  localparam logic [1:0]  OP_MUL   = 2'd3;
  localparam logic [3:0]  CMD_MUL  = 4'hC;
`endif

  state_t      state_q, state_d;
  logic [26:0] a_q, a_d, b_q, b_d;
  logic [1:0]  op_q, op_d;
  logic [3:0]  cnt_q, cnt_d;        // significant digits in the operand being entered
  logic        b_seen_q, b_seen_d;  // a B digit has been keyed since the operator
  logic [27:0] result_q, result_d;  // two's complement
  logic [3:0]  cmd_prev_q;

  logic        ev;
  logic        is_op;
  logic [1:0]  op_code;
  logic [26:0] cur, cur_next;
  logic [28:0] addsub, addsub_mag;

`ifdef CALC_MUL_EN
  logic [53:0] acc_q, acc_d, mcand_q, mcand_d, acc_sum;
  logic [26:0] mplier_q, mplier_d;
  logic [4:0]  mul_cnt_q, mul_cnt_d;
`endif

  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'd0:    seg7 = 7'b0111111;
      4'd1:    seg7 = 7'b0000110;
      4'd2:    seg7 = 7'b1011011;
      4'd3:    seg7 = 7'b1001111;
      4'd4:    seg7 = 7'b1100110;
      4'd5:    seg7 = 7'b1101101;
      4'd6:    seg7 = 7'b1111101;
      4'd7:    seg7 = 7'b0000111;
      4'd8:    seg7 = 7'b1111111;
      4'd9:    seg7 = 7'b1101111;
      default: seg7 = 7'b0000000;
    endcase
  endfunction

  always_comb begin
    is_op   = 1'b0;
    op_code = OP_NONE;
    case (cmd)
      CMD_ADD: begin is_op = 1'b1; op_code = OP_ADD; end
      CMD_SUB: begin is_op = 1'b1; op_code = OP_SUB; end
`ifdef CALC_MUL_EN
      CMD_MUL: begin is_op = 1'b1; op_code = OP_MUL; end
`endif
      default: ;
    endcase
  end

  always_comb begin
    ev         = (cmd != cmd_prev_q);
    cur        = (op_q != OP_NONE) ? b_q : a_q;
    // cur has at most 7 digits whenever this is used, so 27 bits suffice
    cur_next   = cur * 27'd10 + {23'd0, cmd};
    addsub     = (op_q == OP_SUB) ? ({2'b00, a_q} - {2'b00, b_q})
                                  : ({2'b00, a_q} + {2'b00, b_q});
    addsub_mag = addsub[28] ? -addsub : addsub;

    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    b_seen_d = b_seen_q;
    result_d = result_q;
`ifdef CALC_MUL_EN
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    mul_cnt_d = mul_cnt_q;
    acc_sum   = acc_q + (mplier_q[0] ? mcand_q : 54'd0);
`endif

    if (ev) begin
      case (state_q)
        S_EDIT: begin
          if (cmd <= 4'd9) begin
            if (cnt_q != 4'd8) begin
              if (op_q == OP_NONE) a_d = cur_next;
              else                 b_d = cur_next;
              if (cur_next != 27'd0) cnt_d = cnt_q + 4'd1;
              if (op_q != OP_NONE) b_seen_d = 1'b1;
            end
          end else if (is_op) begin
            op_d     = op_code;
            b_d      = 27'd0;
            cnt_d    = 4'd0;
            b_seen_d = 1'b0;
          end else if (cmd == CMD_EQ) begin
            case (op_q)
              OP_NONE: begin
                result_d = {1'b0, a_q};
                state_d  = S_RESULT;
              end
              OP_ADD, OP_SUB: begin
                if (addsub_mag > MAX_MAG) begin
                  state_d = S_ERROR;
                end else begin
                  result_d = addsub[27:0];
                  state_d  = S_RESULT;
                end
              end
`ifdef CALC_MUL_EN
              OP_MUL: begin
                acc_d     = 54'd0;
                mcand_d   = {27'd0, a_q};
                mplier_d  = b_q;
                mul_cnt_d = 5'd26;
                state_d   = S_BUSY;
              end
`endif
              default: ;
            endcase
          end
        end
        S_RESULT: begin
          if (cmd <= 4'd9) begin
            a_d      = {23'd0, cmd};
            cnt_d    = (cmd == 4'd0) ? 4'd0 : 4'd1;
            op_d     = OP_NONE;
            b_d      = 27'd0;
            b_seen_d = 1'b0;
            state_d  = S_EDIT;
          end else if (is_op) begin
            if (result_q[27]) begin
              state_d = S_ERROR;
            end else begin
              a_d      = result_q[26:0];
              op_d     = op_code;
              b_d      = 27'd0;
              cnt_d    = 4'd0;
              b_seen_d = 1'b0;
              state_d  = S_EDIT;
            end
          end
        end
        default: ;
      endcase
    end

`ifdef CALC_MUL_EN
    // One multiplier bit per edge; the 27th edge retires the product.
    if (state_q == S_BUSY) begin
      acc_d    = acc_sum;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      if (mul_cnt_q == 5'd0) begin
        if (acc_sum > 54'd99_999_999) begin
          state_d = S_ERROR;
        end else begin
          result_d = {1'b0, acc_sum[26:0]};
          state_d  = S_RESULT;
        end
      end else begin
        mul_cnt_d = mul_cnt_q - 5'd1;
      end
    end
`endif

    if (ev && cmd == CMD_CLR) begin
      state_d  = S_EDIT;
      a_d      = 27'd0;
      b_d      = 27'd0;
      op_d     = OP_NONE;
      cnt_d    = 4'd0;
      b_seen_d = 1'b0;
      result_d = 28'd0;
`ifdef CALC_MUL_EN
      acc_d     = 54'd0;
      mcand_d   = 54'd0;
      mplier_d  = 27'd0;
      mul_cnt_d = 5'd0;
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= S_EDIT;
      a_q        <= 27'd0;
      b_q        <= 27'd0;
      op_q       <= OP_NONE;
      cnt_q      <= 4'd0;
      b_seen_q   <= 1'b0;
      result_q   <= 28'd0;
      cmd_prev_q <= CMD_IDLE;
`ifdef CALC_MUL_EN
      acc_q      <= 54'd0;
      mcand_q    <= 54'd0;
      mplier_q   <= 27'd0;
      mul_cnt_q  <= 5'd0;
`endif
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      cnt_q      <= cnt_d;
      b_seen_q   <= b_seen_d;
      result_q   <= result_d;
      cmd_prev_q <= cmd;
`ifdef CALC_MUL_EN
      acc_q      <= acc_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      mul_cnt_q  <= mul_cnt_d;
`endif
    end
  end

  assign status = state_q;

  logic [26:0] shown;
  logic [31:0] bcd;
  logic [2:0]  msd;

  always_comb begin
    if (state_q == S_RESULT)
      shown = result_q[27] ? 27'(-result_q) : result_q[26:0];
    else
      shown = (op_q != OP_NONE && b_seen_q) ? b_q : a_q;

    // double-dabble binary to BCD
    bcd = 32'd0;
    for (int i = 26; i >= 0; i--) begin
      for (int d = 0; d < 8; d++)
        if (bcd[d*4 +: 4] >= 4'd5) bcd[d*4 +: 4] = bcd[d*4 +: 4] + 4'd3;
      bcd = {bcd[30:0], shown[i]};
    end

    msd = 3'd0;
    for (int d = 1; d < 8; d++)
      if (bcd[d*4 +: 4] != 4'd0) msd = 3'(d);

    for (int d = 0; d < 8; d++)
      displays[d] = (3'(d) <= msd) ? seg7(bcd[d*4 +: 4]) : 7'b0;

    // an 8-digit negative leaves no room for the sign
    if (state_q == S_RESULT && result_q[27] && msd != 3'd7)
      displays[msd + 3'd1] = SEG_MINUS;

    if (state_q == S_ERROR) begin
      for (int d = 0; d < 8; d++) displays[d] = 7'b0;
      displays[2] = SEG_E;
      displays[1] = SEG_R;
      displays[0] = SEG_R;
    end
  end

endmodule

// File: tb/tb_calc_top.sv
module tb_calc_top;
  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] cmd   = 4'hD;
  logic [6:0] displays [7:0];
  logic [1:0] status;

  calc_top dut (
    .clock(clock),
    .reset(reset),
    .cmd(cmd),
    .displays(displays),
    .status(status)
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int errors  = 0;

`ifdef CALC_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  // Reference model: plain integers, modes numbered as the status codes.
  int     m_mode;
  longint m_a, m_b, m_res, m_prod;
  int     m_op;          // 0 none, 1 add, 2 sub, 3 mul
  bit     m_btyped;
  int     m_prev;
  int     m_busy;

  function automatic logic [6:0] seg_of(input int v);
    case (v)
      0: return 7'b0111111;  1: return 7'b0000110;
      2: return 7'b1011011;  3: return 7'b1001111;
      4: return 7'b1100110;  5: return 7'b1101101;
      6: return 7'b1111101;  7: return 7'b0000111;
      8: return 7'b1111111;  9: return 7'b1101111;
      default: return 7'b0;
    endcase
  endfunction

  function automatic logic [55:0] text_disp(input string s);
    logic [55:0] r;
    byte ch;
    int  n;
    r = '0;
    n = s.len();
    for (int i = 0; i < n; i++) begin
      ch = s[n-1-i];
      if (ch >= 8'h30 && ch <= 8'h39) r[i*7 +: 7] = seg_of(int'(ch) - 48);
      else if (ch == 8'h2D)           r[i*7 +: 7] = 7'b1000000;
      else if (ch == 8'h45)           r[i*7 +: 7] = 7'b1111001;
      else if (ch == 8'h72)           r[i*7 +: 7] = 7'b1010000;
    end
    return r;
  endfunction

  function automatic logic [55:0] dut_disp();
    logic [55:0] r;
    for (int i = 0; i < 8; i++) r[i*7 +: 7] = displays[i];
    return r;
  endfunction

  function automatic logic [55:0] model_disp();
    logic [55:0] r;
    longint v;
    bit neg;
    int n;
    r = '0;
    if (m_mode == 3) return text_disp("Err");
    if (m_mode == 2) begin
      neg = (m_res < 0);
      v   = neg ? -m_res : m_res;
    end else begin
      neg = 1'b0;
      v   = (m_op != 0 && m_btyped) ? m_b : m_a;
    end
    n = 0;
    do begin
      r[n*7 +: 7] = seg_of(int'(v % 10));
      v = v / 10;
      n++;
    end while (v != 0 && n < 8);
    if (neg && n < 8) r[n*7 +: 7] = 7'b1000000;
    return r;
  endfunction

  task automatic model_clear();
    m_mode = 0; m_a = 0; m_b = 0; m_res = 0; m_prod = 0;
    m_op = 0; m_btyped = 0; m_busy = 0;
  endtask

  task automatic model_edge(input logic rst, input logic [3:0] c);
    bit ev, isop;
    int code;
    longint r;
    if (!rst) begin model_clear(); m_prev = 13; return; end
    ev = (int'(c) != m_prev);
    m_prev = int'(c);
    if (ev && c == 4'hF) begin model_clear(); return; end
    if (m_mode == 1) begin
      m_busy--;
      if (m_busy == 0) begin
        if (m_prod > 99_999_999) m_mode = 3;
        else begin m_res = m_prod; m_mode = 2; end
      end
      return;
    end
    if (!ev) return;
    isop = (c == 4'hA) || (c == 4'hB) || (MUL_EN && c == 4'hC);
    code = (c == 4'hA) ? 1 : (c == 4'hB) ? 2 : 3;
    if (m_mode == 0) begin
      if (c <= 4'd9) begin
        if (m_op == 0) begin
          if (m_a < 10_000_000) m_a = m_a * 10 + longint'(c);
        end else begin
          m_btyped = 1;
          if (m_b < 10_000_000) m_b = m_b * 10 + longint'(c);
        end
      end else if (isop) begin
        m_op = code; m_b = 0; m_btyped = 0;
      end else if (c == 4'hE) begin
        if (m_op == 0) begin m_res = m_a; m_mode = 2; end
        else if (m_op == 3) begin m_prod = m_a * m_b; m_busy = 27; m_mode = 1; end
        else begin
          r = (m_op == 1) ? m_a + m_b : m_a - m_b;
          if (r > 99_999_999 || r < -99_999_999) m_mode = 3;
          else begin m_res = r; m_mode = 2; end
        end
      end
    end else if (m_mode == 2) begin
      if (c <= 4'd9) begin
        m_a = longint'(c); m_op = 0; m_b = 0; m_btyped = 0; m_mode = 0;
      end else if (isop) begin
        if (m_res < 0) m_mode = 3;
        else begin m_a = m_res; m_op = code; m_b = 0; m_btyped = 0; m_mode = 0; end
      end
    end
  endtask

  task automatic step();
    model_edge(reset, cmd);
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic press(input logic [3:0] c, input int hold);
    cmd = c;
    repeat (hold) step();
  endtask

  task automatic test_reset();
    cmd = 4'd5; reset = 1'b0;
    repeat (3) step();
    cmd = 4'd7; step();
    vectors++;
    if (dut_disp() !== text_disp("0") || status !== 2'b00) begin
      errors++;
      $display("FAIL reset_hold: disp=%h status=%b want disp=%h status=00",
               dut_disp(), status, text_disp("0"));
    end
    cmd = 4'hD; step();
    reset = 1'b1; step();
    vectors++;
    if (dut_disp() !== text_disp("0") || status !== 2'b00) begin
      errors++;
      $display("FAIL reset_release: disp=%h status=%b want disp=%h status=00",
               dut_disp(), status, text_disp("0"));
    end
  endtask

  task automatic test_add_sequence();
    logic [3:0] codes [5] = '{4'd1, 4'd2, 4'hA, 4'd3, 4'hE};
    string      exp_s [5] = '{"1", "12", "12", "3", "15"};
    logic [1:0] exp_st[5] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b10};
    for (int i = 0; i < 5; i++) begin
      press(codes[i], 12);
      vectors++;
      if (dut_disp() !== text_disp(exp_s[i]) || status !== exp_st[i]) begin
        errors++;
        $display("FAIL add_seq[%0d]: disp=%h status=%b want disp=%h status=%b",
                 i, dut_disp(), status, text_disp(exp_s[i]), exp_st[i]);
      end
    end
  endtask

  task automatic test_sub_negative();
    logic [3:0] codes [6] = '{4'd5, 4'hB, 4'd8, 4'hE, 4'hA, 4'hF};
    string      exp_s [6] = '{"5", "5", "8", "-3", "Err", "0"};
    logic [1:0] exp_st[6] = '{2'b00, 2'b00, 2'b00, 2'b10, 2'b11, 2'b00};
    for (int i = 0; i < 6; i++) begin
      press(codes[i], 12);
      vectors++;
      if (dut_disp() !== text_disp(exp_s[i]) || status !== exp_st[i]) begin
        errors++;
        $display("FAIL sub_neg[%0d]: disp=%h status=%b want disp=%h status=%b",
                 i, dut_disp(), status, text_disp(exp_s[i]), exp_st[i]);
      end
    end
  endtask

  task automatic test_mul();
    int busy;
    press(4'hF, 2);
`ifdef CALC_MUL_EN
    press(4'd1, 12); press(4'd2, 12); press(4'hC, 12); press(4'd3, 12);
    press(4'hE, 1);
    busy = 0;
    while (status == 2'b01 && busy < 60) begin busy++; step(); end
    vectors++;
    if (busy != 27) begin
      errors++;
      $display("FAIL mul_busy_cycles: got %0d want 27", busy);
    end
    vectors++;
    if (dut_disp() !== text_disp("36") || status !== 2'b10) begin
      errors++;
      $display("FAIL mul_result: disp=%h status=%b want disp=%h status=10",
               dut_disp(), status, text_disp("36"));
    end
    press(4'hC, 2); press(4'd2, 2); press(4'hE, 1);
    repeat (10) step();
    vectors++;
    if (status !== 2'b01) begin
      errors++;
      $display("FAIL mul_abort_busy: status=%b want 01", status);
    end
    reset = 1'b0; step();
    cmd = 4'hD; reset = 1'b1;
    repeat (30) step();
    vectors++;
    if (dut_disp() !== text_disp("0") || status !== 2'b00) begin
      errors++;
      $display("FAIL mul_abort: disp=%h status=%b want disp=%h status=00",
               dut_disp(), status, text_disp("0"));
    end
`else
    begin
      logic [3:0] codes [5] = '{4'd1, 4'd2, 4'hC, 4'd3, 4'hE};
      string      exp_s [5] = '{"1", "12", "12", "123", "123"};
      logic [1:0] exp_st[5] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b10};
      for (int i = 0; i < 5; i++) begin
        cmd = codes[i];
        busy = 0;
        for (int k = 0; k < 12; k++) begin
          step();
          if (status == 2'b01) busy++;
        end
        vectors++;
        if (dut_disp() !== text_disp(exp_s[i]) || status !== exp_st[i] || busy != 0) begin
          errors++;
          $display("FAIL nomul[%0d]: disp=%h status=%b busy=%0d want disp=%h status=%b busy=0",
                   i, dut_disp(), status, busy, text_disp(exp_s[i]), exp_st[i]);
        end
      end
    end
`endif
  endtask

  task automatic test_overflow_clear();
    press(4'hF, 2);
    for (int i = 0; i < 8; i++) begin press(4'd9, 2); press(4'hD, 1); end
    vectors++;
    if (dut_disp() !== text_disp("99999999") || status !== 2'b00) begin
      errors++;
      $display("FAIL ovf_entry: disp=%h status=%b want disp=%h", dut_disp(), status,
               text_disp("99999999"));
    end
    press(4'd9, 2);
    vectors++;
    if (dut_disp() !== text_disp("99999999")) begin
      errors++;
      $display("FAIL ovf_ninth_digit: disp=%h want disp=%h", dut_disp(), text_disp("99999999"));
    end
    press(4'hA, 2); press(4'd1, 2); press(4'hE, 2);
    vectors++;
    if (dut_disp() !== text_disp("Err") || status !== 2'b11) begin
      errors++;
      $display("FAIL ovf_err: disp=%h status=%b want disp=%h status=11",
               dut_disp(), status, text_disp("Err"));
    end
    press(4'd5, 2);
    vectors++;
    if (dut_disp() !== text_disp("Err") || status !== 2'b11) begin
      errors++;
      $display("FAIL ovf_sticky: disp=%h status=%b want status=11", dut_disp(), status);
    end
    press(4'hF, 2);
    vectors++;
    if (dut_disp() !== text_disp("0") || status !== 2'b00) begin
      errors++;
      $display("FAIL ovf_clear: disp=%h status=%b want disp=%h status=00",
               dut_disp(), status, text_disp("0"));
    end
  endtask

  task automatic test_hold();
    cmd = 4'd7;
    for (int k = 0; k < 4; k++) begin
      repeat (10) step();
      vectors++;
      if (dut_disp() !== text_disp("7")) begin
        errors++;
        $display("FAIL hold[%0d]: disp=%h want disp=%h", k, dut_disp(), text_disp("7"));
      end
    end
    press(4'hD, 2); press(4'd7, 2);
    vectors++;
    if (dut_disp() !== text_disp("77")) begin
      errors++;
      $display("FAIL hold_repeat: disp=%h want disp=%h", dut_disp(), text_disp("77"));
    end
  endtask

  task automatic test_chain();
    logic [3:0] codes [8] = '{4'd7, 4'hA, 4'd8, 4'hE, 4'hA, 4'd5, 4'hE, 4'd4};
    string      exp_s [8] = '{"7", "7", "8", "15", "15", "5", "20", "4"};
    logic [1:0] exp_st[8] = '{2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b10, 2'b00};
    press(4'hF, 2);
    for (int i = 0; i < 8; i++) begin
      press(codes[i], 3);
      vectors++;
      if (dut_disp() !== text_disp(exp_s[i]) || status !== exp_st[i]) begin
        errors++;
        $display("FAIL chain[%0d]: disp=%h status=%b want disp=%h status=%b",
                 i, dut_disp(), status, text_disp(exp_s[i]), exp_st[i]);
      end
    end
  endtask

  task automatic test_random();
    int r;
    logic [3:0] c;
    press(4'hF, 2);
    for (int n = 0; n < 400; n++) begin
      r = int'($urandom_range(0, 99));
      if (m_mode == 3 && r < 50) c = 4'hF;
      else if (r < 55) c = 4'($urandom_range(0, 9));
      else if (r < 65) c = 4'hA;
      else if (r < 72) c = 4'hB;
      else if (r < 79) c = 4'hC;
      else if (r < 87) c = 4'hD;
      else if (r < 95) c = 4'hE;
      else             c = 4'hF;
      cmd = c;
      repeat (int'($urandom_range(1, 3))) begin
        step();
        vectors++;
        if (dut_disp() !== model_disp() || status !== 2'(m_mode)) begin
          errors++;
          $display("FAIL random[%0d] cmd=%h: disp=%h status=%b want disp=%h status=%0d",
                   n, c, dut_disp(), status, model_disp(), m_mode);
        end
      end
    end
  endtask

  initial begin
    model_clear();
    m_prev = 13;
    @(negedge clock);
    test_reset();
    test_add_sequence();
    test_sub_negative();
    test_mul();
    test_overflow_clear();
    test_hold();
    test_chain();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, got running want finished");
    $fatal(1, "timeout");
  end

endmodule
